elevator_call_panel: RTL and testbench

//  Passenger-side front end of the elevator: the request producer and service observer. Takes
//  raw, bouncing car (floor) buttons and hall call buttons. Debounces them and drives one-cycle

---
 rtl/elevator_pkg.sv | 16 +
 rtl/elevator_debounce.sv | 48 ++++
 rtl/elevator_call_panel.sv | 99 +++++++++
 tb/tb_elevator_call_panel.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared constants and per-button state encoding for the elevator passenger panel.
package elevator_pkg;

    localparam int NFLR_DEFAULT      = 4;
    localparam int FLR_W             = 2;
    localparam int DB_CYCLES_DEFAULT = 16;

    // PEND is the only state with the lamp lit; SVCD/HELD wait for a release.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        SVCD = 2'd2,
        HELD = 2'd3
    } btn_state_e;

endpackage

// File: rtl/elevator_debounce.sv
// One-bit 2-FF synchronizer plus stability counter; rise pulses for one cycle when db goes high.
module elevator_debounce #(
    parameter int DB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic db,
    output logic rise
);

    localparam int CNT_W = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic             sync1_reg;
    logic             sync2_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             db_reg;
    logic             rise_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            cnt_reg   <= '0;
            db_reg    <= 1'b0;
            rise_reg  <= 1'b0;
        end else begin
            sync1_reg <= raw;
            sync2_reg <= sync1_reg;
            rise_reg  <= 1'b0;
            if (sync2_reg == db_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_MAX) begin
                // Stable long enough: commit the new level.
                db_reg   <= sync2_reg;
                rise_reg <= sync2_reg;
                cnt_reg  <= '0;
            end else begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    assign db   = db_reg;
    assign rise = rise_reg;

endmodule

// File: rtl/elevator_call_panel.sv
// Passenger panel: debounces car/hall buttons, issues one-cycle requests and tracks lamps
// until the car is at the floor with the door open.
module elevator_call_panel
    import elevator_pkg::*;
#(
    parameter int NFLR      = NFLR_DEFAULT,
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NFLR-1:0]  raw_fb,
    input  logic [NFLR-1:0]  raw_call,
    input  logic [3:0]       Door,
    input  logic [FLR_W-1:0] curFlr,
    output logic [NFLR-1:0]  FB,
    output logic [NFLR-1:0]  Call,
    output logic [NFLR-1:0]  fb_lamp,
    output logic [NFLR-1:0]  call_lamp,
    output logic             busy
);

    // Bits [NFLR-1:0] are car buttons, [2*NFLR-1:NFLR] are hall buttons.
    logic [2*NFLR-1:0] raw_all;
    logic [2*NFLR-1:0] db_all;
    logic [2*NFLR-1:0] rise_all;
    logic [2*NFLR-1:0] lamp_all;
    logic [2*NFLR-1:0] pulse_all;
    logic [NFLR-1:0]   svc;

    assign raw_all = {raw_call, raw_fb};

    for (genvar gi = 0; gi < NFLR; gi++) begin : g_svc
        assign svc[gi] = (Door != 4'd0) && (int'(curFlr) == gi);
    end

    for (genvar gi = 0; gi < 2*NFLR; gi++) begin : g_btn
        localparam int FLR = gi % NFLR;

        btn_state_e state_reg;
        logic       lamp_reg;
        logic       pulse_reg;

        elevator_debounce #(
            .DB_CYCLES (DB_CYCLES)
        ) u_db (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (raw_all[gi]),
            .db    (db_all[gi]),
            .rise  (rise_all[gi])
        );

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_reg <= IDLE;
                lamp_reg  <= 1'b0;
                pulse_reg <= 1'b0;
            end else begin
                pulse_reg <= 1'b0;
                unique case (state_reg)
                    IDLE: begin
                        if (rise_all[gi]) begin
                            if (svc[FLR]) begin
                                state_reg <= HELD;
                            end else begin
                                state_reg <= PEND;
                                lamp_reg  <= 1'b1;
                                pulse_reg <= 1'b1;
                            end
                        end
                    end
                    PEND: begin
                        // A fresh press while pending is a duplicate and is dropped.
                        if (svc[FLR]) begin
                            state_reg <= SVCD;
                            lamp_reg  <= 1'b0;
                        end
                    end
                    SVCD: begin
                        if (!db_all[gi]) state_reg <= IDLE;
                    end
                    HELD: begin
                        if (!db_all[gi]) state_reg <= IDLE;
                    end
                endcase
            end
        end

        assign lamp_all[gi]  = lamp_reg;
        assign pulse_all[gi] = pulse_reg;
    end

    assign FB        = pulse_all[NFLR-1:0];
    assign Call      = pulse_all[2*NFLR-1:NFLR];
    assign fb_lamp   = lamp_all[NFLR-1:0];
    assign call_lamp = lamp_all[2*NFLR-1:NFLR];
    assign busy      = |lamp_all;

endmodule

// File: tb/tb_elevator_call_panel.sv
// Directed bench for elevator_call_panel with DB_CYCLES=4: request latency, glitch rejection,
// duplicate suppression, service clearing, simultaneous presses and mid-operation reset.
module tb_elevator_call_panel;

    logic       clk;
    logic       rst_n;
    logic [3:0] raw_fb;
    logic [3:0] raw_call;
    logic [3:0] Door;
    logic [1:0] curFlr;
    logic [3:0] FB;
    logic [3:0] Call;
    logic [3:0] fb_lamp;
    logic [3:0] call_lamp;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    elevator_call_panel #(
        .NFLR      (4),
        .DB_CYCLES (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .raw_fb    (raw_fb),
        .raw_call  (raw_call),
        .Door      (Door),
        .curFlr    (curFlr),
        .FB        (FB),
        .Call      (Call),
        .fb_lamp   (fb_lamp),
        .call_lamp (call_lamp),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Step n edges; pulses expected only after edge pulse_edge (0 = none), lamps switch then too.
    task automatic run_edges(input string tag, input int n, input int pulse_edge,
                             input logic [3:0] exp_fb, input logic [3:0] exp_call,
                             input logic [3:0] fbl_before, input logic [3:0] fbl_after,
                             input logic [3:0] cl_before, input logic [3:0] cl_after);
        for (int e = 1; e <= n; e++) begin
            @(posedge clk);
            #2;
            chk({tag, "_FB"},   32'(FB),   (e == pulse_edge) ? 32'(exp_fb)   : 32'd0);
            chk({tag, "_Call"}, 32'(Call), (e == pulse_edge) ? 32'(exp_call) : 32'd0);
            chk({tag, "_fb_lamp"},   32'(fb_lamp),
                (pulse_edge != 0 && e >= pulse_edge) ? 32'(fbl_after) : 32'(fbl_before));
            chk({tag, "_call_lamp"}, 32'(call_lamp),
                (pulse_edge != 0 && e >= pulse_edge) ? 32'(cl_after) : 32'(cl_before));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [3:0] bounce;

        rst_n    = 1'b0;
        raw_fb   = 4'b0000;
        raw_call = 4'b0000;
        Door     = 4'h0;
        curFlr   = 2'd0;
        tick();
        tick();
        chk("reset_FB",   32'(FB),   32'd0);
        chk("reset_Call", 32'(Call), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_lamps", 32'({fb_lamp, call_lamp}), 32'd0);

        // 1: held car button 2, pulse after edge 7
        rst_n  = 1'b1;
        raw_fb = 4'b0100;
        run_edges("t1", 9, 7, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000);
        chk("t1_busy", 32'(busy), 32'd1);
        $display("T1 single press latency: checks=%0d failures=%0d", checks, failures);

        // 2: hall button 1 bounces 1,0,1,0 and must be rejected
        bounce = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            raw_call = {2'b00, bounce[i], 1'b0};
            tick();
            chk("t2_bounce_Call", 32'(Call), 32'd0);
        end
        raw_call = 4'b0000;
        run_edges("t2", 12, 0, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b0000);
        $display("T2 glitch rejection: checks=%0d failures=%0d", checks, failures);

        // 3: car button 3 pressed, released, pressed again, then serviced
        raw_fb = 4'b1100;
        run_edges("t3a", 9, 7, 4'b1000, 4'b0000, 4'b0100, 4'b1100, 4'b0000, 4'b0000);
        raw_fb = 4'b0100;
        run_edges("t3b", 8, 0, 4'b0000, 4'b0000, 4'b1100, 4'b1100, 4'b0000, 4'b0000);
        raw_fb = 4'b1100;
        run_edges("t3c", 9, 0, 4'b0000, 4'b0000, 4'b1100, 4'b1100, 4'b0000, 4'b0000);
        curFlr = 2'd3;
        Door   = 4'h1;
        tick();
        chk("t3_clear_fb_lamp", 32'(fb_lamp), 32'b0100);
        chk("t3_busy", 32'(busy), 32'd1);
        Door   = 4'h0;
        raw_fb = 4'b0100;
        run_edges("t3d", 8, 0, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b0000);
        $display("T3 duplicate and service clear: checks=%0d failures=%0d", checks, failures);

        // 4: press at a serviced floor is ignored, later press is accepted
        curFlr   = 2'd1;
        Door     = 4'hF;
        raw_call = 4'b0010;
        run_edges("t4a", 9, 0, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b0000);
        raw_call = 4'b0000;
        Door     = 4'h0;
        run_edges("t4b", 8, 0, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b0000);
        raw_call = 4'b0010;
        run_edges("t4c", 9, 7, 4'b0000, 4'b0010, 4'b0100, 4'b0100, 4'b0000, 4'b0010);
        $display("T4 press at serviced floor: checks=%0d failures=%0d", checks, failures);

        // Drain: release everything and service floors 2 and 1
        raw_fb   = 4'b0000;
        raw_call = 4'b0000;
        run_edges("drain", 8, 0, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0010, 4'b0010);
        curFlr = 2'd2;
        Door   = 4'h1;
        tick();
        chk("drain_fb_lamp",   32'(fb_lamp),   32'd0);
        chk("drain_call_lamp", 32'(call_lamp), 32'b0010);
        curFlr = 2'd1;
        tick();
        chk("drain_call_lamp2", 32'(call_lamp), 32'd0);
        chk("drain_busy", 32'(busy), 32'd0);
        Door = 4'h0;
        tick();
        tick();

        // 5: six buttons rise together
        raw_fb   = 4'b1111;
        raw_call = 4'b1001;
        run_edges("t5", 9, 7, 4'b1111, 4'b1001, 4'b0000, 4'b1111, 4'b0000, 4'b1001);
        chk("t5_busy", 32'(busy), 32'd1);
        $display("T5 simultaneous presses: checks=%0d failures=%0d", checks, failures);

        // 6: asynchronous reset with lamps pending and buttons held
        rst_n = 1'b0;
        #1;
        chk("t6_async_FB",    32'(FB),    32'd0);
        chk("t6_async_Call",  32'(Call),  32'd0);
        chk("t6_async_lamps", 32'({fb_lamp, call_lamp}), 32'd0);
        chk("t6_async_busy",  32'(busy),  32'd0);
        tick();
        chk("t6_inrst_lamps", 32'({fb_lamp, call_lamp}), 32'd0);
        rst_n = 1'b1;
        run_edges("t6", 9, 7, 4'b1111, 4'b1001, 4'b0000, 4'b1111, 4'b0000, 4'b1001);
        $display("T6 mid-operation reset: checks=%0d failures=%0d", checks, failures);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
